key_switch_conditioner: RTL and testbench
=========================================

// Module: key_switch_conditioner
// PURPOSE
//  Sits directly downstream of the board input wrapper; takes its raw pass-through pins.
//  Synchronizes and debounces the four active-low push keys (reset/set/load/start).
//  Emits clean active-high levels plus one-cycle press pulses for the clock/scene control FSMs.
//  Double-flop synchronizes all toggle switches and mode switches before any downstream use.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles required to accept a key change (10 ms @ 50 MHz); >=2
//  REPEAT_DELAY     25000000  held cycles from press pulse to first repeat pulse (AUTOREPEAT_EN only)
//  REPEAT_PERIOD    10000000  cycles between subsequent repeat pulses (AUTOREPEAT_EN only)
// PORTS
//  clk                      in   1  system clock (the wrapper's clkOut)
//  reset                    in   1  synchronous, active-high reset
//  resetSetLoadStartIn      in   4  raw keys, active-low (0 = pressed), asynchronous
//  toggleSwitches17To14In   in   4  raw toggle switches, asynchronous
//  toggleSwitches13To10In   in   4  raw toggle switches, asynchronous
//  demoOrRealModeIn         in   1  raw mode switch
//  monitorOrMissedSceneIn   in   1  raw scene switch
//  keyLevelOut              out  4  debounced key state, active-high (1 = held)
//  keyPressPulseOut         out  4  one-cycle pulse per accepted press (and per repeat)
//  toggleSwitches17To14Out  out  4  synchronized switches
//  toggleSwitches13To10Out  out  4  synchronized switches
//  demoOrRealModeOut        out  1  synchronized mode switch
//  monitorOrMissedSceneOut  out  1  synchronized scene switch
// BEHAVIOUR
//  - Reset: key sync flops <= 1 (released); keyLevelOut = 0; keyPressPulseOut = 0; all counters = 0.
//    All switch sync flops and switch outputs = 0. Reset mid-debounce or mid-hold discards all progress.
//  - Sync: every input passes through 2 flops. Key path is inverted after sync (pressed = 1).
//  - Per key, independent: counter cnt is $clog2(DEBOUNCE_CYCLES) bits.
//    - If sync != keyLevel: cnt increments.
//    - If sync != keyLevel and cnt == DEBOUNCE_CYCLES-1: keyLevel toggles, cnt <= 0.
//    - If sync == keyLevel: cnt <= 0, so any bounce restarts the count.
//  - Latency: keyLevelOut changes on the (DEBOUNCE_CYCLES+2)th rising edge.
//    Counting starts at the edge that first samples the new raw level, provided the raw level holds.
//  - keyPressPulseOut[i] = 1 for exactly the first cycle keyLevelOut[i] is 1. Release produces no pulse.
//  - Simultaneous presses on several keys give simultaneous, independent pulses. No priority logic.
//  - Switch outputs lag raw inputs by exactly 2 cycles. No debounce is applied to switches.
// CONFIGURATION
//  Macro KEY_SWITCH_CONDITIONER_AUTOREPEAT_EN:
//   Defined: a per-key hold counter runs while keyLevel = 1.
//    - Extra pulse REPEAT_DELAY cycles after the press pulse.
//    - Then one pulse every REPEAT_PERIOD cycles while the key is held.
//    - Release or reset clears the hold counter immediately. No pulse is issued in the release cycle.
//   Undefined: no hold counters are built; exactly one pulse per press. REPEAT_* parameters are ignored.
// TESTING (bench: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
//  1. Reset asserted, keys raw=4'hF -> keyLevelOut=0, keyPressPulseOut=0, switch outs=0.
//     Release reset -> outputs stay 0.
//  2. key0 raw 1->0 held -> keyLevelOut[0]=1 on 6th edge, keyPressPulseOut=4'b0001 for 1 cycle only.
//  3. key1 raw low 3 cycles, high 1, low 3 (bounce) -> no level change. Then hold low 6 -> single pulse.
//  4. Keys 2 and 3 pressed on the same edge -> keyPressPulseOut=4'b1100 in one cycle.
//     Release -> levels drop after 6 edges, no pulse.
//  5. Assert reset at cnt=2 during a key0 press -> level stays 0.
//     After reset release, a full 6-edge hold is needed for the pulse.
//  6. toggleSwitches17To14In=4'hA -> Out=4'hA after 2 cycles.
//     AUTOREPEAT_EN: hold key0 20 cycles -> pulses at press, +8, +11, +14, +17. Release -> none.

Source files
------------

// File: rtl/key_switch_conditioner.sv
// Key debouncer with press pulses, plus 2-flop synchronizers for switches.
// Optional hold-to-repeat pulses: define KEY_SWITCH_CONDITIONER_AUTOREPEAT_EN.
module key_switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] resetSetLoadStartIn,
    input  logic [3:0] toggleSwitches17To14In,
    input  logic [3:0] toggleSwitches13To10In,
    input  logic       demoOrRealModeIn,
    input  logic       monitorOrMissedSceneIn,
    output logic [3:0] keyLevelOut,
    output logic [3:0] keyPressPulseOut,
    output logic [3:0] toggleSwitches17To14Out,
    output logic [3:0] toggleSwitches13To10Out,
    output logic       demoOrRealModeOut,
    output logic       monitorOrMissedSceneOut
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [3:0]    r_key_s1;
    logic [3:0]    r_key_s2;
    logic [3:0]    r_level;
    logic [3:0]    r_pulse;
    logic [CW-1:0] r_cnt [4];
    logic [9:0]    r_sw_s1;
    logic [9:0]    r_sw_s2;

    logic [3:0] w_key_sync;
    logic [3:0] w_hit;
    logic [3:0] w_press;
    logic [3:0] w_pulse_next;

    assign w_key_sync = ~r_key_s2;

    // w_hit: the new level has been stable long enough to be accepted now
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < 4; i++) begin
            w_hit[i] = (w_key_sync[i] != r_level[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    assign w_press = w_hit & ~r_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_s1 <= '1;
            r_key_s2 <= '1;
            r_level  <= '0;
            r_pulse  <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_key_s1 <= resetSetLoadStartIn;
            r_key_s2 <= r_key_s1;
            r_level  <= r_level ^ w_hit;
            r_pulse  <= w_pulse_next;
            r_sw_s1  <= {toggleSwitches17To14In, toggleSwitches13To10In,
                         demoOrRealModeIn, monitorOrMissedSceneIn};
            r_sw_s2  <= r_sw_s1;
            for (int i = 0; i < 4; i++) begin
                if (w_key_sync[i] == r_level[i] || w_hit[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

`ifdef KEY_SWITCH_CONDITIONER_AUTOREPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [HW-1:0] DLY_MAX = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PER_MAX = HW'(REPEAT_PERIOD - 1);
    localparam logic [HW-1:0] HLD_ONE = HW'(1);

    logic [HW-1:0] r_hold [4];
    logic [3:0]    r_rep;
    logic [3:0]    w_release;
    logic [3:0]    w_repeat;

    assign w_release = w_hit & r_level;

    // r_rep selects the repeat period once the initial delay has elapsed
    always_comb begin
        w_repeat = '0;
        for (int i = 0; i < 4; i++) begin
            w_repeat[i] = r_level[i] && !w_release[i] &&
                          (r_hold[i] == (r_rep[i] ? PER_MAX : DLY_MAX));
        end
    end

    assign w_pulse_next = w_press | w_repeat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep <= '0;
            for (int i = 0; i < 4; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!r_level[i] || w_release[i]) begin
                    r_hold[i] <= '0;
                    r_rep[i]  <= 1'b0;
                end else if (w_repeat[i]) begin
                    r_hold[i] <= '0;
                    r_rep[i]  <= 1'b1;
                end else begin
                    r_hold[i] <= r_hold[i] + HLD_ONE;
                end
            end
        end
    end
`else
    logic w_unused_repeat_cfg;

    assign w_unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
    assign w_pulse_next        = w_press;
`endif

    assign keyLevelOut             = r_level;
    assign keyPressPulseOut        = r_pulse;
    assign toggleSwitches17To14Out = r_sw_s2[9:6];
    assign toggleSwitches13To10Out = r_sw_s2[5:2];
    assign demoOrRealModeOut       = r_sw_s2[1];
    assign monitorOrMissedSceneOut = r_sw_s2[0];

endmodule

// File: tb/tb_key_switch_conditioner.sv
// Bench for key_switch_conditioner: directed spec scenarios then random
// key/switch activity, checked against a cycle-level behavioural model.
module tb_key_switch_conditioner;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] keys_raw;
    logic [3:0] sw17_raw;
    logic [3:0] sw13_raw;
    logic       demo_raw;
    logic       mon_raw;
    logic [3:0] key_level;
    logic [3:0] key_pulse;
    logic [3:0] sw17_out;
    logic [3:0] sw13_out;
    logic       demo_out;
    logic       mon_out;

    key_switch_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .resetSetLoadStartIn    (keys_raw),
        .toggleSwitches17To14In (sw17_raw),
        .toggleSwitches13To10In (sw13_raw),
        .demoOrRealModeIn       (demo_raw),
        .monitorOrMissedSceneIn (mon_raw),
        .keyLevelOut            (key_level),
        .keyPressPulseOut       (key_pulse),
        .toggleSwitches17To14Out(sw17_out),
        .toggleSwitches13To10Out(sw13_out),
        .demoOrRealModeOut      (demo_out),
        .monitorOrMissedSceneOut(mon_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: raw samples seen on the last two edges, the accepted level, how
    // many consecutive edges the synchronized key has disagreed with it, and
    // the number of edges since the accepted press.
    bit [3:0] m_raw1, m_raw2;
    bit [9:0] m_sw1, m_sw2;
    bit [3:0] m_level, m_pulse;
    int       m_streak [4];
    int       m_age    [4];

    function automatic bit repeat_due(int age);
`ifdef KEY_SWITCH_CONDITIONER_AUTOREPEAT_EN
        return (age == RD) || (age > RD && (age - RD) % RP == 0);
`else
        return (age < 0);
`endif
    endfunction

    task automatic model_edge();
        bit [3:0] old_level;
        if (reset) begin
            m_raw1 = '1; m_raw2 = '1;
            m_sw1 = '0;  m_sw2 = '0;
            m_level = '0; m_pulse = '0;
            for (int i = 0; i < 4; i++) begin
                m_streak[i] = 0;
                m_age[i] = 0;
            end
        end else begin
            old_level = m_level;
            for (int i = 0; i < 4; i++) begin
                if (bit'(!m_raw2[i]) != m_level[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] == D) begin
                        m_level[i] = ~m_level[i];
                        m_streak[i] = 0;
                    end
                end else begin
                    m_streak[i] = 0;
                end
                m_pulse[i] = 1'b0;
                if (m_level[i] && !old_level[i]) begin
                    m_age[i] = 0;
                    m_pulse[i] = 1'b1;
                end else if (m_level[i]) begin
                    m_age[i]++;
                    m_pulse[i] = repeat_due(m_age[i]);
                end
            end
            m_raw2 = m_raw1;
            m_raw1 = keys_raw;
            m_sw2 = m_sw1;
            m_sw1 = {sw17_raw, sw13_raw, demo_raw, mon_raw};
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        n_vec++;
        assert ({key_level, key_pulse} === {m_level, m_pulse})
        else begin
            n_err++;
            $error("FAIL %s keys: got level=%b pulse=%b, expected level=%b pulse=%b",
                   tag, key_level, key_pulse, m_level, m_pulse);
        end
        n_vec++;
        assert ({sw17_out, sw13_out, demo_out, mon_out} === m_sw2)
        else begin
            n_err++;
            $error("FAIL %s switches: got %b expected %b", tag,
                   {sw17_out, sw13_out, demo_out, mon_out}, m_sw2);
        end
    endtask

    task automatic steps(input int n, input string tag);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    initial begin
        reset = 1'b1;
        keys_raw = 4'hF;
        sw17_raw = 4'h5; sw13_raw = 4'h3;
        demo_raw = 1'b1; mon_raw = 1'b1;
        steps(3, "reset");
        reset = 1'b0;
        sw17_raw = 4'h0; sw13_raw = 4'h0;
        demo_raw = 1'b0; mon_raw = 1'b0;
        steps(4, "post_reset");

        keys_raw = 4'b1110;
        steps(9, "key0_press");
        keys_raw = 4'hF;
        steps(8, "key0_release");

        keys_raw = 4'b1101; steps(3, "key1_bounce");
        keys_raw = 4'hF;    steps(1, "key1_bounce");
        keys_raw = 4'b1101; steps(3, "key1_bounce");
        steps(6, "key1_hold");
        keys_raw = 4'hF;
        steps(8, "key1_release");

        keys_raw = 4'b0011;
        steps(8, "key23_press");
        keys_raw = 4'hF;
        steps(8, "key23_release");

        keys_raw = 4'b1110;
        steps(4, "key0_pre_reset");
        reset = 1'b1;
        steps(1, "key0_mid_reset");
        reset = 1'b0;
        steps(8, "key0_after_reset");
        keys_raw = 4'hF;
        steps(8, "key0_release2");

        sw17_raw = 4'hA; sw13_raw = 4'h6;
        demo_raw = 1'b1; mon_raw = 1'b0;
        steps(3, "switches");
        sw17_raw = 4'h3; sw13_raw = 4'h9;
        demo_raw = 1'b0; mon_raw = 1'b1;
        steps(3, "switches2");

        keys_raw = 4'b1110;
        steps(26, "key0_hold_repeat");
        keys_raw = 4'hF;
        steps(10, "key0_hold_release");

        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 6) == 0) keys_raw[i] = ~keys_raw[i];
            end
            sw17_raw = 4'($urandom);
            sw13_raw = 4'($urandom);
            demo_raw = 1'($urandom);
            mon_raw  = 1'($urandom);
            reset    = ($urandom_range(0, 149) == 0);
            step("random");
        end
        reset = 1'b0;
        keys_raw = 4'hF;
        steps(10, "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
